// File: rtl/tpu_pkg.sv
// Shared PE definitions: default datapath widths and saturation bounds.
package tpu_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int PSUM_WIDTH = 32;

   // Bounds are returned as the p-bit pattern in the low bits of a 64-bit word.
   function automatic logic [63:0] sat_max(input int p, input bit sgn);
      if (sgn)
         return (64'd1 << (p - 1)) - 64'd1;
      else if (p >= 64)
         return '1;
      else
         return (64'd1 << p) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int p, input bit sgn);
      if (sgn)
         return 64'd1 << (p - 1);
      else
         return 64'd0;
   endfunction

endpackage

// File: rtl/pe_dbuf_mac_if.sv
// Neighbour-facing bus of the double-buffered MAC PE.
interface pe_dbuf_mac_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] ifmap_i;
   logic                  ifmap_valid_i;
   logic [DATA_WIDTH-1:0] weight_i;
   logic                  weight_load_i;
   logic                  weight_swap_i;
   logic [PSUM_WIDTH-1:0] psum_i;
   logic [DATA_WIDTH-1:0] ifmap_o;
   logic                  ifmap_valid_o;
   logic [DATA_WIDTH-1:0] weight_o;
   logic                  weight_load_o;
   logic                  weight_swap_o;
   logic [PSUM_WIDTH-1:0] psum_o;
   logic                  psum_valid_o;
   logic                  overflow_o;

   modport master (
      output ifmap_i, ifmap_valid_i, weight_i, weight_load_i, weight_swap_i, psum_i,
      input  ifmap_o, ifmap_valid_o, weight_o, weight_load_o, weight_swap_o,
             psum_o, psum_valid_o, overflow_o
   );

   modport slave (
      input  ifmap_i, ifmap_valid_i, weight_i, weight_load_i, weight_swap_i, psum_i,
      output ifmap_o, ifmap_valid_o, weight_o, weight_load_o, weight_swap_o,
             psum_o, psum_valid_o, overflow_o
   );
endinterface

// File: rtl/pe_mac_sat.sv
// Combinational accumulate: extend product, add to psum, detect overflow and optionally clamp.
module pe_mac_sat #(
   parameter int PSUM_WIDTH = 32,
   parameter int PROD_WIDTH = 16,
   parameter bit SIGNED     = 1'b1,
   parameter bit SATURATE   = 1'b1
) (
   input  logic [PSUM_WIDTH-1:0] psum,
   input  logic [PROD_WIDTH-1:0] prod,
   output logic [PSUM_WIDTH-1:0] sum,
   output logic                  ovf
);
   import tpu_pkg::*;

   localparam logic [63:0]           MAX64   = sat_max(PSUM_WIDTH, SIGNED);
   localparam logic [63:0]           MIN64   = sat_min(PSUM_WIDTH, SIGNED);
   localparam logic [PSUM_WIDTH-1:0] SAT_MAX = MAX64[PSUM_WIDTH-1:0];
   localparam logic [PSUM_WIDTH-1:0] SAT_MIN = MIN64[PSUM_WIDTH-1:0];

   logic [PSUM_WIDTH:0] a_x;
   logic [PSUM_WIDTH:0] b_x;
   logic [PSUM_WIDTH:0] s_x;

   always_comb begin
      if (SIGNED) begin
         a_x = (PSUM_WIDTH+1)'($signed(psum));
         b_x = (PSUM_WIDTH+1)'($signed(prod));
      end else begin
         a_x = (PSUM_WIDTH+1)'(psum);
         b_x = (PSUM_WIDTH+1)'(prod);
      end
      s_x = a_x + b_x;

      if (SIGNED)
         ovf = (psum[PSUM_WIDTH-1] == prod[PROD_WIDTH-1]) &&
               (s_x[PSUM_WIDTH-1] != psum[PSUM_WIDTH-1]);
      else
         ovf = s_x[PSUM_WIDTH];

      // On signed overflow both operands share a sign, so psum's sign picks the rail.
      if (SATURATE && ovf)
         sum = (SIGNED && psum[PSUM_WIDTH-1]) ? SAT_MIN : SAT_MAX;
      else
         sum = s_x[PSUM_WIDTH-1:0];
   end
endmodule

// File: rtl/pe_dbuf_mac.sv
// Weight-stationary systolic PE with shadow/active weight double buffer and 2-stage MAC.
module pe_dbuf_mac #(
   parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
   parameter int PSUM_WIDTH = tpu_pkg::PSUM_WIDTH,
   parameter bit SIGNED     = 1'b1,
   parameter bit SATURATE   = 1'b1
) (
   input logic          clk,
   input logic          rst,
   pe_dbuf_mac_if.slave bus
);
   import tpu_pkg::*;

   localparam int PW = 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] ifmap_r;
   logic                  ifmap_valid_r;
   logic                  weight_load_r;
   logic                  weight_swap_r;
   logic [DATA_WIDTH-1:0] shadow_r;
   logic [DATA_WIDTH-1:0] active_r;
   logic [PW-1:0]         prod_r;
   logic [PSUM_WIDTH-1:0] psum_d_r;
   logic                  v1_r;
   logic [PSUM_WIDTH-1:0] psum_r;
   logic                  ovf_r;
   logic                  v2_r;

   logic [PW-1:0]         prod_c;
   logic [PSUM_WIDTH-1:0] sum_c;
   logic                  ovf_c;

   always_comb begin
      if (SIGNED)
         prod_c = PW'($signed(bus.ifmap_i)) * PW'($signed(active_r));
      else
         prod_c = PW'(bus.ifmap_i) * PW'(active_r);
   end

   pe_mac_sat #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .PROD_WIDTH (PW),
      .SIGNED     (SIGNED),
      .SATURATE   (SATURATE)
   ) u_mac_sat (
      .psum (psum_d_r),
      .prod (prod_r),
      .sum  (sum_c),
      .ovf  (ovf_c)
   );

   // Swap reads shadow_r before the same-edge load overwrites it, so active gets the old shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifmap_r       <= '0;
         ifmap_valid_r <= 1'b0;
         weight_load_r <= 1'b0;
         weight_swap_r <= 1'b0;
         shadow_r      <= '0;
         active_r      <= '0;
         prod_r        <= '0;
         psum_d_r      <= '0;
         v1_r          <= 1'b0;
         psum_r        <= '0;
         ovf_r         <= 1'b0;
         v2_r          <= 1'b0;
      end else begin
         ifmap_valid_r <= bus.ifmap_valid_i;
         weight_load_r <= bus.weight_load_i;
         weight_swap_r <= bus.weight_swap_i;
         v1_r          <= bus.ifmap_valid_i;
         v2_r          <= v1_r;
         if (bus.ifmap_valid_i) begin
            ifmap_r  <= bus.ifmap_i;
            prod_r   <= prod_c;
            psum_d_r <= bus.psum_i;
         end
         if (bus.weight_load_i)
            shadow_r <= bus.weight_i;
         if (bus.weight_swap_i)
            active_r <= shadow_r;
         if (v1_r) begin
            psum_r <= sum_c;
            ovf_r  <= ovf_c;
         end
      end
   end

   assign bus.ifmap_o       = ifmap_r;
   assign bus.ifmap_valid_o = ifmap_valid_r;
   assign bus.weight_o      = shadow_r;
   assign bus.weight_load_o = weight_load_r;
   assign bus.weight_swap_o = weight_swap_r;
   assign bus.psum_o        = psum_r;
   assign bus.psum_valid_o  = v2_r;
   assign bus.overflow_o    = ovf_r;
endmodule
